// File: rtl/fnd_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : fnd_scan_decoder
// Purpose  : Rebuilds 4-digit frames from a scanned active-low 7-segment bus.
// Revision : 1.0
// ============================================================================
module fnd_scan_decoder #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 200_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  fnd_com,
    input  logic [7:0]  fnd_data,
    output logic [15:0] value,
    output logic [3:0]  dp,
    output logic [13:0] bin_value,
    output logic        bcd_ok,
    output logic        frame_valid,
    output logic        active,
    output logic        seg_err,
    output logic        seq_err
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_LOAD    = 2'd2;

    logic [3:0]    com_m_q, com_s_q, com_p_q;
    logic [7:0]    data_m_q, data_s_q, data_p_q;
    logic [SW-1:0] settle_q;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [1:0]    state_q, state_d;
    logic [1:0]    last_q, last_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [3:0]    shdp_q, shdp_d;
    logic          active_d, seg_err_d, seq_err_d;

    logic          w_changed, w_cap, w_idx_ok, w_glyph_ok, w_store, w_bcd_ok;
    logic [1:0]    w_idx;
    logic [3:0]    w_nib;
    logic [13:0]   w_bin;

    // The *_p_q pair is the previous synchronised sample; it also holds the captured pattern.
    assign w_changed = (com_s_q != com_p_q) || (data_s_q != data_p_q);
    assign w_cap     = (settle_q == SETTLE_LAST) && (com_p_q != 4'hF);

    always_comb begin
        w_idx_ok = 1'b1;
        w_idx    = 2'd0;
        case (com_p_q)
            4'b1110: w_idx = 2'd0;
            4'b1101: w_idx = 2'd1;
            4'b1011: w_idx = 2'd2;
            4'b0111: w_idx = 2'd3;
            default: w_idx_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_glyph_ok = 1'b1;
        w_nib      = 4'h0;
        case (data_p_q[6:0])
            7'h40: w_nib = 4'h0;
            7'h79: w_nib = 4'h1;
            7'h24: w_nib = 4'h2;
            7'h30: w_nib = 4'h3;
            7'h19: w_nib = 4'h4;
            7'h12: w_nib = 4'h5;
            7'h02: w_nib = 4'h6;
            7'h78: w_nib = 4'h7;
            7'h00: w_nib = 4'h8;
            7'h10: w_nib = 4'h9;
            7'h08: w_nib = 4'hA;
            7'h03: w_nib = 4'hB;
            7'h46: w_nib = 4'hC;
            7'h21: w_nib = 4'hD;
            7'h06: w_nib = 4'hE;
            7'h0E: w_nib = 4'hF;
            default: w_glyph_ok = 1'b0;
        endcase
    end

    assign w_bcd_ok = (shadow_q[3:0] <= 4'd9) && (shadow_q[7:4] <= 4'd9) &&
                      (shadow_q[11:8] <= 4'd9) && (shadow_q[15:12] <= 4'd9);
    assign w_bin    = w_bcd_ok ? (14'(shadow_q[15:12]) * 14'd1000 + 14'(shadow_q[11:8]) * 14'd100 +
                                  14'(shadow_q[7:4]) * 14'd10 + 14'(shadow_q[3:0])) : 14'd0;

    always_comb begin
        state_d   = (state_q == ST_LOAD) ? ST_IDLE : state_q;
        last_d    = last_q;
        shadow_d  = shadow_q;
        shdp_d    = shdp_q;
        tmo_d     = tmo_q;
        active_d  = active;
        seg_err_d = 1'b0;
        seq_err_d = 1'b0;
        w_store   = 1'b0;
        if (w_cap) begin
            tmo_d    = '0;
            active_d = 1'b1;
            if (!w_idx_ok) begin
                seq_err_d = 1'b1;
                state_d   = ST_IDLE;
            end else if (!w_glyph_ok) begin
                seg_err_d = 1'b1;
                state_d   = ST_IDLE;
            end else if (state_q == ST_COLLECT && w_idx == last_q + 2'd1) begin
                w_store = 1'b1;
                state_d = (w_idx == 2'd3) ? ST_LOAD : ST_COLLECT;
            end else if (w_idx == 2'd0) begin
                // An index-0 capture always (re)starts a frame; mid-frame it is also an error.
                seq_err_d = (state_q == ST_COLLECT);
                w_store   = 1'b1;
                state_d   = ST_COLLECT;
            end else if (state_q == ST_COLLECT) begin
                seq_err_d = 1'b1;
                state_d   = ST_IDLE;
            end
        end else if (tmo_q != TIMEOUT_MAX) begin
            tmo_d = tmo_q + TW'(1);
        end else begin
            active_d = 1'b0;
            state_d  = ST_IDLE;
        end
        if (w_store) begin
            last_d                = w_idx;
            shadow_d[w_idx*4 +: 4] = w_nib;
            shdp_d[w_idx]         = ~data_p_q[7];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            com_m_q     <= '0;
            com_s_q     <= '0;
            com_p_q     <= '0;
            data_m_q    <= '0;
            data_s_q    <= '0;
            data_p_q    <= '0;
            settle_q    <= '0;
            tmo_q       <= '0;
            state_q     <= ST_IDLE;
            last_q      <= '0;
            shadow_q    <= '0;
            shdp_q      <= '0;
            value       <= '0;
            dp          <= '0;
            bin_value   <= '0;
            bcd_ok      <= 1'b0;
            frame_valid <= 1'b0;
            active      <= 1'b0;
            seg_err     <= 1'b0;
            seq_err     <= 1'b0;
        end else begin
            com_m_q  <= fnd_com;
            com_s_q  <= com_m_q;
            com_p_q  <= com_s_q;
            data_m_q <= fnd_data;
            data_s_q <= data_m_q;
            data_p_q <= data_s_q;
            if (w_changed) begin
                settle_q <= '0;
            end else if (settle_q != SETTLE_MAX) begin
                settle_q <= settle_q + SW'(1);
            end
            tmo_q       <= tmo_d;
            state_q     <= state_d;
            last_q      <= last_d;
            shadow_q    <= shadow_d;
            shdp_q      <= shdp_d;
            active      <= active_d;
            seg_err     <= seg_err_d;
            seq_err     <= seq_err_d;
            frame_valid <= (state_q == ST_LOAD);
            if (state_q == ST_LOAD) begin
                value     <= shadow_q;
                dp        <= shdp_q;
                bin_value <= w_bin;
                bcd_ok    <= w_bcd_ok;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fnd_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_fnd_scan_decoder
// Purpose  : Directed and random scans checked against a frame-level model.
// Revision : 1.0
// ============================================================================
module tb_fnd_scan_decoder;
    localparam int S   = 16;
    localparam int TMO = 400;
    localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  fnd_com;
    logic [7:0]  fnd_data;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [13:0] bin_value;
    logic        bcd_ok, frame_valid, active, seg_err, seq_err;

    always #5 clk = ~clk;

    fnd_scan_decoder #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .fnd_com(fnd_com), .fnd_data(fnd_data),
        .value(value), .dp(dp), .bin_value(bin_value), .bcd_ok(bcd_ok),
        .frame_valid(frame_valid), .active(active), .seg_err(seg_err), .seq_err(seq_err)
    );

    typedef struct packed {
        logic [15:0] v;
        logic [3:0]  d;
        logic [13:0] b;
        logic        ok;
    } frame_t;

    frame_t      exp_q[$];
    frame_t      got_q[$];
    frame_t      mon_f;
    int          n_tests = 0, n_fail = 0;
    int          d_seg = 0, d_seq = 0, m_seg = 0, m_seq = 0;
    int          need = -1, gap = 0, cur_len = 0, ptr = 0;
    logic [3:0]  dg [4];
    logic [3:0]  dpm;
    logic [15:0] m_value;
    logic        m_active;
    logic [3:0]  cur_c;
    logic [7:0]  cur_d;

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (frame_valid) begin
                mon_f.v  = value;
                mon_f.d  = dp;
                mon_f.b  = bin_value;
                mon_f.ok = bcd_ok;
                got_q.push_back(mon_f);
            end
            if (seg_err) d_seg++;
            if (seq_err) d_seq++;
        end
    end

    function automatic int glyph_of(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (GLYPH[i] == p) return i;
        return -1;
    endfunction

    function automatic int index_of(input logic [3:0] c);
        for (int i = 0; i < 4; i++) if (c == ~(4'b0001 << i)) return i;
        return -1;
    endfunction

    task automatic push_frame();
        frame_t f;
        f.v  = {dg[3], dg[2], dg[1], dg[0]};
        f.d  = dpm;
        f.ok = (dg[0] <= 9) && (dg[1] <= 9) && (dg[2] <= 9) && (dg[3] <= 9);
        f.b  = f.ok ? 14'(int'(dg[3]) * 1000 + int'(dg[2]) * 100 + int'(dg[1]) * 10 + int'(dg[0])) : 14'd0;
        m_value = f.v;
        exp_q.push_back(f);
    endtask

    // One stable window of a nonblank pattern, interpreted at frame level.
    task automatic model_capture(input logic [3:0] c, input logic [7:0] d);
        int idx, g;
        if (gap >= TMO) need = -1;
        m_active = 1'b1;
        idx = index_of(c);
        g   = glyph_of(d[6:0]);
        if (idx < 0) begin
            m_seq++; need = -1;
        end else if (g < 0) begin
            m_seg++; need = -1;
        end else if (need >= 0 && idx == need) begin
            dg[idx] = 4'(g); dpm[idx] = ~d[7];
            if (idx == 3) begin push_frame(); need = -1; end
            else need = idx + 1;
        end else if (idx == 0) begin
            if (need >= 0) m_seq++;
            dg[0] = 4'(g); dpm[0] = ~d[7]; need = 1;
        end else if (need >= 0) begin
            m_seq++; need = -1;
        end
    endtask

    task automatic close_seg();
        if (cur_len >= S && cur_c != 4'hF) begin
            gap = gap + S + 2;
            model_capture(cur_c, cur_d);
            gap = cur_len - S - 2;
        end else begin
            gap = gap + cur_len;
        end
    endtask

    task automatic model_reset();
        need = -1; gap = 0; m_value = '0; m_active = 1'b0;
        cur_c = 4'hF; cur_d = 8'hFF; cur_len = 0;
        exp_q.delete(); got_q.delete();
    endtask

    task automatic drive(input logic [3:0] c, input logic [7:0] d, input int len);
        if (c != cur_c || d != cur_d) begin
            close_seg();
            cur_c = c; cur_d = d; cur_len = 0;
        end
        fnd_com  = c;
        fnd_data = d;
        cur_len  = cur_len + len;
        repeat (len) @(negedge clk);
    endtask

    task automatic checkpoint(input string tag);
        frame_t e, g;
        drive(4'hF, 8'hFF, S + 8);
        check({tag, "/frames"}, 40'(got_q.size()), 40'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            check({tag, "/value"}, 40'(g.v), 40'(e.v));
            check({tag, "/dp"}, 40'(g.d), 40'(e.d));
            check({tag, "/bin"}, 40'(g.b), 40'(e.b));
            check({tag, "/bcd_ok"}, 40'(g.ok), 40'(e.ok));
        end
        exp_q.delete(); got_q.delete();
        check({tag, "/seg_err"}, 40'(d_seg), 40'(m_seg));
        check({tag, "/seq_err"}, 40'(d_seq), 40'(m_seq));
        check({tag, "/held"}, 40'(value), 40'(m_value));
        check({tag, "/active"}, 40'(active), 40'(m_active && (gap + cur_len < TMO)));
    endtask

    task automatic scan42();
        drive(4'b1110, 8'hA4, 64);
        drive(4'b1101, 8'h99, 64);
        drive(4'b1011, 8'hC0, 64);
        drive(4'b0111, 8'hC0, 64);
    endtask

    initial begin
        reset_n = 1'b0; fnd_com = 4'hF; fnd_data = 8'hFF;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset/outputs", 40'({value, dp, bin_value, bcd_ok, frame_valid, active, seg_err, seq_err}), 40'd0);
        reset_n = 1'b1;

        scan42();
        checkpoint("t1");
        check("t1/bin_const", 40'(bin_value), 40'd42);

        drive(4'b1110, 8'h8E, 40); drive(4'b1101, 8'h86, 40);
        drive(4'b1011, 8'h86, 40); drive(4'b0111, 8'h83, 40);
        checkpoint("t2");
        check("t2/value_const", 40'(value), 40'h0BEEF);

        drive(4'b1110, 8'hF9, 10); drive(4'b1110, 8'hA4, 64);
        drive(4'b1101, 8'hF9, 40); drive(4'b1011, 8'hA4, 40); drive(4'b0111, 8'hB0, 40);
        checkpoint("t3");

        drive(4'b1110, 8'hC0, 64); drive(4'b1011, 8'hC0, 64);
        checkpoint("t4_err");
        scan42();
        checkpoint("t4_ok");

        drive(4'b1110, 8'hFF, 64); drive(4'b1100, 8'hC0, 64);
        checkpoint("t5");

        for (int n = 0; n < 80; n++) begin
            logic [3:0] c;
            logic [7:0] d;
            int         r, len;
            bit         forced;
            forced = (gap + cur_len > 250);
            r = forced ? 0 : $urandom_range(0, 99);
            if (r < 70) begin
                c = ~(4'b0001 << ptr); ptr = (ptr + 1) % 4;
            end else if (r < 80) begin
                c = ~(4'b0001 << $urandom_range(0, 3));
            end else if (r < 88) begin
                c = 4'hF;
            end else begin
                c = 4'($urandom);
                while (index_of(c) >= 0 || c == 4'hF) c = 4'($urandom);
            end
            if (forced || $urandom_range(0, 99) < 85) d = {1'($urandom_range(0, 1)), GLYPH[$urandom_range(0, 15)]};
            else d = 8'($urandom);
            len = (forced || $urandom_range(0, 4) != 0) ? $urandom_range(S, S + 30) : $urandom_range(1, S - 1);
            drive(c, d, len);
            if (n % 20 == 19) checkpoint("rand");
        end

        scan42();
        checkpoint("t6_pre");
        drive(4'b1110, 8'hC0, 40); drive(4'b1101, 8'hC0, 40);
        drive(4'hF, 8'hFF, TMO + 60);
        check("t6/active_low", 40'(active), 40'd0);
        check("t6/value_held", 40'(value), 40'(m_value));
        drive(4'b1011, 8'hC0, 40); drive(4'b0111, 8'hC0, 40);
        checkpoint("t6_post");

        drive(4'b1110, 8'hA4, 40); drive(4'b1101, 8'h99, 40);
        close_seg(); cur_len = 0;
        fnd_com = 4'b1011; fnd_data = 8'hC0;
        repeat (10) @(negedge clk);
        #3 reset_n = 1'b0;
        #1 check("t6/async_reset", 40'({value, dp, bin_value, bcd_ok, frame_valid, active, seg_err, seq_err}), 40'd0);
        @(negedge clk);
        fnd_com = 4'hF; fnd_data = 8'hFF;
        repeat (2) @(negedge clk);
        model_reset();
        reset_n = 1'b1;
        scan42();
        checkpoint("t6_clean");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
